dpcm_frame_ctrl: RTL and testbench
==================================

Name: dpcm_frame_ctrl

Overview:
- Frame-level sequencer for the 4x4 DPCM compression engine.
- Walks an IMG_W x IMG_H 8-bit image held in a synchronous pixel RAM, one 4x4 block at a time in block-raster order.
- Per block: gathers 16 pixels into a 128-bit block word, runs the engine through its start/start_ack and finish/finish_ack handshakes, then emits the 144-bit residual word plus mode bit on a valid/ready output stream.
- Sits between the image buffer and the bitstream packer.

Parameters:
- W, 8, pixel width in bits
- N, 16, pixels per block (fixed 4x4)
- IMG_W, 8, image width in pixels; multiple of 4, >= 4
- IMG_H, 8, image height in pixels; multiple of 4, >= 4
- AW, 6, pixel RAM address width; 2^AW >= IMG_W*IMG_H
- BW, 2, block index width; 2^BW >= (IMG_W/4)*(IMG_H/4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- frame_start  in  1  single-cycle request to process one frame; honoured only in IDLE
- frame_busy  out  1  high from the cycle after an accepted frame_start until frame_done
- frame_done  out  1  one-cycle pulse after the last block is accepted at the output
- mem_rd  out  1  pixel RAM read strobe
- mem_addr  out  AW  pixel RAM address, row*IMG_W + col
- mem_rdata  in  W  read data, valid exactly one cycle after mem_rd
- eng_start  out  1  engine start request
- eng_start_ack  in  1  engine accepted the block
- eng_data_in  out  N*W  block word to the engine
- eng_finish  in  1  engine result ready; held until acknowledged
- eng_finish_ack  out  1  result consumed
- eng_mode  in  1  engine-selected scan mode; valid while eng_finish is high
- eng_data_out  in  N*W+N  engine residual word; valid while eng_finish is high
- out_valid  out  1  output word valid
- out_ready  in  1  downstream ready
- out_data  out  N*W+N  captured residual word
- out_mode  out  1  captured mode bit
- out_blk_idx  out  BW  block index, br*(IMG_W/4)+bc

Behaviour:
- Reset: all outputs 0; FSM in IDLE; block row/col counters 0; block buffer 0.
  - Reset mid-frame abandons the frame. No frame_done is produced.
  - The engine shares rst, so it is also back in idle.
- FSM states: IDLE, FETCH, START, WAIT, CAPTURE, OUT, DONE.
- IDLE:
  - On frame_start: set frame_busy, clear br/bc, go to FETCH.
- FETCH: 17 cycles.
  - Cycles 0-15: mem_rd=1, mem_addr = (4*br+k/4)*IMG_W + 4*bc + k%4, for k = 0..15.
  - Cycles 1-16: mem_rdata is written to eng_data_in[N*W-1-W*(k) -: W].
  - Pixel k=0 (top-left) therefore lands in the MSB byte; packing is row-major within the block.
  - After cycle 16, go to START.
- START:
  - eng_start=1 while eng_start_ack=0.
  - On the cycle eng_start_ack=1, deassert eng_start (registered, so low on the following edge) and go to WAIT.
  - eng_data_in is held stable from the end of FETCH until WAIT is left.
- WAIT:
  - Stay until eng_finish=1, then go to CAPTURE.
- CAPTURE: one cycle.
  - Latch out_data <= eng_data_out, out_mode <= eng_mode, out_blk_idx <= br*(IMG_W/4)+bc.
  - Drive eng_finish_ack=1 for exactly this one cycle; it is never held longer.
  - Go to OUT.
- OUT:
  - out_valid=1; out_data, out_mode and out_blk_idx are stable while out_valid is high.
  - On out_valid & out_ready:
    - Drop out_valid.
    - Advance bc; bc wraps to 0 at IMG_W/4 and increments br.
    - If this was the last block (br=IMG_H/4-1 and bc=IMG_W/4-1), go to DONE; otherwise go to FETCH.
  - Indefinite out_ready=0 stalls the FSM with no data loss.
- DONE:
  - Pulse frame_done for one cycle, clear frame_busy, return to IDLE.
- frame_start while busy is ignored and is not queued.
- frame_start in the same cycle as the DONE pulse is ignored; it is accepted only in IDLE.
- Unexpected eng_finish outside WAIT is ignored.
- eng_start_ack outside START is ignored.
- Per-block latency excluding engine time and output stall: 17 fetch + 1 START minimum + 1 CAPTURE + 1 OUT.

Decomposition:
- Shared package dpcm_pkg holds:
  - W, N, BLK_DIM=4
  - the residual width constant N*W+N
  - the FSM state encoding constants
- One natural sub-module: dpcm_blk_addr_gen.
  - Holds the br/bc/k counters.
  - Produces mem_addr, a last-pixel flag and a last-block flag.
  - Leaves the FSM responsible only for handshakes.

Test Plan:
- IMG_W=IMG_H=4, mem[a]=a, engine model acks after 3 cycles -> eng_data_in=0x000102030405060708090A0B0C0D0E0F at the start handshake; exactly one out word with out_blk_idx=0; frame_done one cycle after acceptance.
- IMG_W=IMG_H=8, mem[a]=a -> 4 blocks in order 0,1,2,3. Block 1 fetch addresses are 4,5,6,7,12,13,14,15,20,21,22,23,28,29,30,31; eng_data_in MSB byte is 0x04.
- Engine model returns eng_data_out=0x5A pattern, eng_mode=1 -> out_data and out_mode match; eng_finish_ack high exactly one cycle per block; eng_start deasserts the cycle after eng_start_ack.
- Hold out_ready=0 for 20 cycles on block 2 -> out_valid and out_data stable, no next FETCH until acceptance, total of 4 words.
- frame_start pulsed during WAIT of block 0 -> ignored; exactly 4 outputs and one frame_done.
- rst low during FETCH of block 1 -> all outputs 0 next cycle, no frame_done; a new frame_start restarts at block 0 with address 0.

Source files
------------

// File: rtl/dpcm_pkg.sv
// Shared constants for the 4x4 DPCM frame sequencer: block geometry,
// residual word width and FSM state encodings.
package dpcm_pkg;

  localparam int W       = 8;
  localparam int N       = 16;
  localparam int BLK_DIM = 4;
  localparam int RES_W   = N*W + N;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

endpackage

// File: rtl/dpcm_blk_addr_gen.sv
// Block-raster address generator: holds block row/col and in-block pixel
// counters and turns them into pixel RAM addresses and end-of-walk flags.
module dpcm_blk_addr_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6,
  parameter int BW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          pix_inc,
  input  logic          blk_inc,
  output logic [4:0]    pix_k,
  output logic [AW-1:0] addr,
  output logic          last_blk,
  output logic [BW-1:0] blk_idx
);
  import dpcm_pkg::*;

  localparam int NBC = IMG_W / BLK_DIM;
  localparam int NBR = IMG_H / BLK_DIM;
  localparam int CW  = (NBC > 1) ? $clog2(NBC) : 1;
  localparam int RWD = (NBR > 1) ? $clog2(NBR) : 1;

  logic [4:0]     k_q, k_d;
  logic [CW-1:0]  bc_q, bc_d;
  logic [RWD-1:0] br_q, br_d;
  logic           last_bc, last_br;

  assign last_bc  = (bc_q == CW'(NBC - 1));
  assign last_br  = (br_q == RWD'(NBR - 1));
  assign last_blk = last_bc && last_br;
  assign pix_k    = k_q;

  // k runs 0..16 during a fetch: 16 read cycles plus one drain cycle.
  always_comb begin
    k_d  = k_q;
    bc_d = bc_q;
    br_d = br_q;
    if (clear) begin
      k_d  = '0;
      bc_d = '0;
      br_d = '0;
    end else begin
      if (pix_inc) k_d = k_q[4] ? 5'd0 : k_q + 5'd1;
      if (blk_inc) begin
        if (last_bc) begin
          bc_d = '0;
          br_d = last_br ? '0 : br_q + RWD'(1);
        end else begin
          bc_d = bc_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q  <= '0;
      bc_q <= '0;
      br_q <= '0;
    end else begin
      k_q  <= k_d;
      bc_q <= bc_d;
      br_q <= br_d;
    end
  end

  assign addr = AW'((int'(br_q) * BLK_DIM + int'(k_q[3:2])) * IMG_W
                    + int'(bc_q) * BLK_DIM + int'(k_q[1:0]));
  assign blk_idx = BW'(int'(br_q) * NBC + int'(bc_q));

endmodule

// File: rtl/dpcm_frame_ctrl.sv
// Frame sequencer: fetches each 4x4 block from pixel RAM, hands it to the
// DPCM engine and streams the residual word out on a valid/ready port.
module dpcm_frame_ctrl #(
  parameter int W     = dpcm_pkg::W,
  parameter int N     = dpcm_pkg::N,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6,
  parameter int BW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [W-1:0]      mem_rdata,
  output logic              eng_start,
  input  logic              eng_start_ack,
  output logic [N*W-1:0]    eng_data_in,
  input  logic              eng_finish,
  output logic              eng_finish_ack,
  input  logic              eng_mode,
  input  logic [N*W+N-1:0]  eng_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*W+N-1:0]  out_data,
  output logic              out_mode,
  output logic [BW-1:0]     out_blk_idx
);
  import dpcm_pkg::*;

  localparam int RW = N*W + N;

  logic [2:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic          start_q, start_d;
  logic [N*W-1:0] blk_q, blk_d;
  logic [RW-1:0] out_data_q, out_data_d;
  logic          out_mode_q, out_mode_d;
  logic [BW-1:0] out_idx_q, out_idx_d;
  logic          rd_q, rd_d;
  logic [3:0]    widx_q, widx_d;

  logic          ag_clear, ag_pix_inc, ag_blk_inc;
  logic [4:0]    pix_k;
  logic [AW-1:0] ag_addr;
  logic          last_blk;
  logic [BW-1:0] blk_idx;

  dpcm_blk_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW),
    .BW    (BW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (ag_clear),
    .pix_inc  (ag_pix_inc),
    .blk_inc  (ag_blk_inc),
    .pix_k    (pix_k),
    .addr     (ag_addr),
    .last_blk (last_blk),
    .blk_idx  (blk_idx)
  );

  assign mem_rd         = (state_q == S_FETCH) && !pix_k[4];
  assign mem_addr       = mem_rd ? ag_addr : '0;
  assign frame_busy     = busy_q;
  assign frame_done     = (state_q == S_DONE);
  assign eng_start      = start_q;
  assign eng_data_in    = blk_q;
  assign eng_finish_ack = (state_q == S_CAPTURE);
  assign out_valid      = (state_q == S_OUT);
  assign out_data       = out_data_q;
  assign out_mode       = out_mode_q;
  assign out_blk_idx    = out_idx_q;

  // Read data returns one cycle after the strobe, so the write slot trails
  // the read index by one cycle; the last pixel lands on the FETCH->START edge.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    start_d    = 1'b0;
    blk_d      = blk_q;
    out_data_d = out_data_q;
    out_mode_d = out_mode_q;
    out_idx_d  = out_idx_q;
    rd_d       = mem_rd;
    widx_d     = pix_k[3:0];
    ag_clear   = 1'b0;
    ag_pix_inc = 1'b0;
    ag_blk_inc = 1'b0;

    if (rd_q) blk_d[N*W-1-W*int'(widx_q) -: W] = mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          busy_d   = 1'b1;
          ag_clear = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        ag_pix_inc = 1'b1;
        if (pix_k[4]) begin
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (eng_start_ack) state_d = S_WAIT;
        else               start_d = 1'b1;
      end
      S_WAIT: begin
        if (eng_finish) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        out_data_d = eng_data_out;
        out_mode_d = eng_mode;
        out_idx_d  = blk_idx;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          ag_blk_inc = 1'b1;
          state_d    = last_blk ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      blk_q      <= '0;
      out_data_q <= '0;
      out_mode_q <= 1'b0;
      out_idx_q  <= '0;
      rd_q       <= 1'b0;
      widx_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      blk_q      <= blk_d;
      out_data_q <= out_data_d;
      out_mode_q <= out_mode_d;
      out_idx_q  <= out_idx_d;
      rd_q       <= rd_d;
      widx_q     <= widx_d;
    end
  end

endmodule

// File: tb/tb_dpcm_frame_ctrl.sv
// Self-checking bench for dpcm_frame_ctrl on an 8x8 image: RAM and engine
// models, scoreboarded addresses/outputs, table-driven frame scenarios.
module tb_dpcm_frame_ctrl;

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_start;
  logic           frame_busy, frame_done;
  logic           mem_rd;
  logic [5:0]     mem_addr;
  logic [7:0]     mem_rdata = 8'd0;
  logic           eng_start;
  logic           eng_start_ack = 1'b0;
  logic [127:0]   eng_data_in;
  logic           eng_finish = 1'b0;
  logic           eng_finish_ack;
  logic           eng_mode = 1'b0;
  logic [143:0]   eng_data_out = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [143:0]   out_data;
  logic           out_mode;
  logic [1:0]     out_blk_idx;

  dpcm_frame_ctrl #(
    .W(8), .N(16), .IMG_W(8), .IMG_H(8), .AW(6), .BW(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .frame_busy     (frame_busy),
    .frame_done     (frame_done),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .eng_start      (eng_start),
    .eng_start_ack  (eng_start_ack),
    .eng_data_in    (eng_data_in),
    .eng_finish     (eng_finish),
    .eng_finish_ack (eng_finish_ack),
    .eng_mode       (eng_mode),
    .eng_data_out   (eng_data_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_mode       (out_mode),
    .out_blk_idx    (out_blk_idx)
  );

  always #5 clk = ~clk;

  // Pixel RAM holding mem[a] = a, one-cycle read latency.
  always @(posedge clk) if (mem_rd) mem_rdata <= {2'b00, mem_addr};

  typedef struct {
    int stall_blk;
    int stall_len;
    int ack_dly;
    int fin_dly;
    bit extra_fs;
    int exp_words;
  } vec_t;

  typedef struct {
    logic [143:0] data;
    logic         mode;
    logic [1:0]   idx;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int frame_id = 0;
  int seen_frame = 0;
  int cur_stall_blk = -1;
  int cur_stall_len = 0;
  int cur_ack_dly = 3;
  int cur_fin_dly = 4;
  int words = 0;
  int dones = 0;
  int last_acc = -10;
  int job = 0;
  int eng_phase = 0;
  int eng_cnt = 0;
  int stall_used = 0;

  logic [5:0] exp_addr_q[$];
  exp_t       exp_out_q[$];

  task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] blkWord(input int j);
    logic [127:0] w;
    int a;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      a = (4*(j/2) + k/4)*8 + 4*(j%2) + k%4;
      w[127-8*k -: 8] = 8'(a);
    end
    return w;
  endfunction

  function automatic logic [143:0] engData(input int j, input int f);
    logic [143:0] d;
    d = {18{8'h5A}};
    d[7:0]     = d[7:0] ^ 8'(j);
    d[143:136] = d[143:136] ^ 8'(f);
    return d;
  endfunction

  function automatic logic engMode(input int j);
    return (j != 1);
  endfunction

  // Engine, downstream and monitor model; everything sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (!rst) begin
      eng_start_ack = 1'b0;
      eng_finish    = 1'b0;
      out_ready     = 1'b0;
      eng_phase     = 0;
      eng_cnt       = 0;
    end else begin
      if (frame_id != seen_frame) begin
        seen_frame = frame_id;
        job        = 0;
        words      = 0;
        stall_used = 0;
      end
      if (mem_rd) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL mem_rd_unexpected got addr %0d expected no read", mem_addr);
        end else begin
          checkOutput("mem_addr", 144'(mem_addr), 144'(exp_addr_q.pop_front()));
        end
      end
      if (eng_finish_ack) begin
        checkOutput("finish_ack_single", 144'(eng_finish), 144'(1'b1));
        eng_finish = 1'b0;
        eng_phase  = 0;
        eng_cnt    = 0;
        job++;
      end else begin
        case (eng_phase)
          0: if (eng_start) begin
               if (eng_cnt >= cur_ack_dly) begin
                 checkOutput("eng_data_in", 144'(eng_data_in), 144'(blkWord(job)));
                 eng_start_ack = 1'b1;
                 eng_phase     = 2;
               end else eng_cnt++;
             end
          2: begin
               checkOutput("eng_start_drop", 144'(eng_start), 144'(1'b0));
               eng_start_ack = 1'b0;
               eng_phase     = 3;
               eng_cnt       = 0;
             end
          3: if (eng_cnt >= cur_fin_dly) begin
               eng_finish   = 1'b1;
               eng_data_out = engData(job, frame_id);
               eng_mode     = engMode(job);
               eng_phase    = 4;
             end else eng_cnt++;
          default: ;
        endcase
      end
      out_ready = 1'b0;
      if (out_valid) begin
        if (exp_out_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL out_unexpected got idx %0d expected no word", out_blk_idx);
        end else begin
          e = exp_out_q[0];
          if (int'(e.idx) == cur_stall_blk && stall_used < cur_stall_len) begin
            stall_used++;
            checkOutput("stall_data", out_data, e.data);
            checkOutput("stall_idx", 144'(out_blk_idx), 144'(e.idx));
          end else begin
            out_ready = 1'b1;
            checkOutput("out_data", out_data, e.data);
            checkOutput("out_mode", 144'(out_mode), 144'(e.mode));
            checkOutput("out_blk_idx", 144'(out_blk_idx), 144'(e.idx));
            void'(exp_out_q.pop_front());
            words++;
            last_acc = cycle;
          end
        end
      end
      if (frame_done) begin
        dones++;
        checkOutput("done_latency", 144'(cycle - last_acc), 144'(1));
        checkOutput("busy_in_done", 144'(frame_busy), 144'(1'b1));
      end
    end
  end

  task automatic waitDone(input int snap);
    int n;
    n = 0;
    while (dones == snap && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (dones == snap) begin
      checks++; errors++;
      $display("[TB] FAIL frame_done_timeout got no done expected done within 3000 cycles");
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int snap, n;
    exp_t e;
    cur_stall_blk = v.stall_blk;
    cur_stall_len = v.stall_len;
    cur_ack_dly   = v.ack_dly;
    cur_fin_dly   = v.fin_dly;
    snap = dones;
    frame_id++;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 16; k++)
        exp_addr_q.push_back(6'((4*(j/2) + k/4)*8 + 4*(j%2) + k%4));
      e.data = engData(j, frame_id);
      e.mode = engMode(j);
      e.idx  = 2'(j);
      exp_out_q.push_back(e);
    end
    @(negedge clk); #1;
    frame_start = 1'b1;
    @(negedge clk); #1;
    frame_start = 1'b0;
    checkOutput("busy_after_start", 144'(frame_busy), 144'(1'b1));
    if (v.extra_fs) begin
      n = 0;
      while (!eng_start_ack && n < 500) begin
        @(negedge clk); #1;
        n++;
      end
      @(negedge clk); #1;
      frame_start = 1'b1;
      @(negedge clk); #1;
      frame_start = 1'b0;
    end
    waitDone(snap);
    @(negedge clk); #1;
    checkOutput("busy_after_done", 144'(frame_busy), 144'(1'b0));
    checkOutput("words_per_frame", 144'(words), 144'(v.exp_words));
    checkOutput("dones_per_frame", 144'(dones - snap), 144'(1));
    checkOutput("addr_queue_empty", 144'(exp_addr_q.size()), 144'(0));
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_busy", 144'(frame_busy), 144'(0));
    checkOutput("rst_done", 144'(frame_done), 144'(0));
    checkOutput("rst_mem_rd", 144'(mem_rd), 144'(0));
    checkOutput("rst_mem_addr", 144'(mem_addr), 144'(0));
    checkOutput("rst_eng_start", 144'(eng_start), 144'(0));
    checkOutput("rst_eng_data_in", 144'(eng_data_in), 144'(0));
    checkOutput("rst_finish_ack", 144'(eng_finish_ack), 144'(0));
    checkOutput("rst_out_valid", 144'(out_valid), 144'(0));
    checkOutput("rst_out_data", out_data, 144'(0));
    checkOutput("rst_out_mode", 144'(out_mode), 144'(0));
    checkOutput("rst_out_idx", 144'(out_blk_idx), 144'(0));
  endtask

  vec_t vecs[4];

  initial begin
    int snap, n;
    vecs[0] = '{stall_blk: -1, stall_len: 0,  ack_dly: 3, fin_dly: 4, extra_fs: 1'b0, exp_words: 4};
    vecs[1] = '{stall_blk: 2,  stall_len: 20, ack_dly: 3, fin_dly: 4, extra_fs: 1'b0, exp_words: 4};
    vecs[2] = '{stall_blk: -1, stall_len: 0,  ack_dly: 3, fin_dly: 6, extra_fs: 1'b1, exp_words: 4};
    vecs[3] = '{stall_blk: 0,  stall_len: 5,  ack_dly: 0, fin_dly: 0, extra_fs: 1'b0, exp_words: 4};

    rst = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs();
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      $display("[TB] scenario %0d", i);
      applyStimulus(vecs[i]);
    end

    // Reset during the fetch of block 1 abandons the frame.
    cur_stall_blk = -1;
    cur_stall_len = 0;
    cur_ack_dly   = 3;
    cur_fin_dly   = 4;
    frame_id++;
    for (int k = 0; k < 64; k++) exp_addr_q.push_back(6'((4*((k/16)/2) + (k%16)/4)*8 + 4*((k/16)%2) + (k%16)%4));
    exp_out_q.push_back('{data: engData(0, frame_id), mode: engMode(0), idx: 2'd0});
    @(negedge clk); #1;
    frame_start = 1'b1;
    @(negedge clk); #1;
    frame_start = 1'b0;
    n = 0;
    while (!(words == 1 && mem_rd) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("reached_block1_fetch", 144'(words == 1 && mem_rd), 144'(1));
    snap = dones;
    rst = 1'b0;
    #1;
    checkResetOutputs();
    exp_addr_q.delete();
    exp_out_q.delete();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("no_done_after_reset", 144'(dones - snap), 144'(0));
    applyStimulus(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
